// File: rtl/rv_pkg.sv
// Shared constants and types for the register-file writeback path.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = $clog2(NREG);

  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LOAD = 2'd1,
    WB_SKID = 2'd2,
    WB_ALU  = 2'd3
  } wb_src_e;

endpackage

// File: rtl/rd_fifo.sv
// Small FIFO of destination indices for loads still awaiting their response.
// Pointers wrap naturally (power-of-two depth); occupancy is tracked in its own counter.
module rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port owner: arbitrates load responses, a one-entry ALU skid and
// direct ALU results, and keeps a busy scoreboard so issue stalls on hazards.
module rf_wb_scoreboard #(
  parameter int unsigned NREG       = rv_pkg::NREG,
  parameter int unsigned XLEN       = rv_pkg::XLEN,
  parameter int unsigned LOAD_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          issue_valid_i,
  input  logic [rv_pkg::REG_W-1:0]      issue_rd_i,
  input  logic [rv_pkg::REG_W-1:0]      issue_rs1_i,
  input  logic [rv_pkg::REG_W-1:0]      issue_rs2_i,
  input  logic                          issue_use_rs1_i,
  input  logic                          issue_use_rs2_i,
  input  logic                          issue_is_load_i,
  output logic                          issue_stall_o,
  input  logic                          alu_valid_i,
  input  logic [rv_pkg::REG_W-1:0]      alu_rd_i,
  input  logic [XLEN-1:0]               alu_data_i,
  output logic                          alu_ready_o,
  input  logic                          lsu_rsp_valid_i,
  input  logic [XLEN-1:0]               lsu_rsp_data_i,
  output logic                          rf_we_o,
  output logic [rv_pkg::REG_W-1:0]      rf_waddr_o,
  output logic [XLEN-1:0]               rf_wdata_o,
  output logic [$clog2(LOAD_DEPTH):0]   load_pending_o,
  output logic                          err_o
);

  import rv_pkg::*;

  logic [NREG-1:0]  busy_q, busy_d;
  logic             skid_valid_q, skid_valid_d;
  logic [REG_W-1:0] skid_rd_q, skid_rd_d;
  logic [XLEN-1:0]  skid_data_q, skid_data_d;
  logic             rf_we_q, rf_load_q, err_q;
  logic [REG_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q;

  logic             fifo_full_s, fifo_empty_s, load_win_s, load_push_s;
  logic [REG_W-1:0] fifo_head_s;
  logic             raw1_s, raw2_s, waw_s, full_stall_s;
  wb_src_e          wb_src_s;
  logic [REG_W-1:0] wb_rd_s;
  logic [XLEN-1:0]  wb_data_s;

  // A source is hazardous while its producer is still in flight anywhere on the write path.
  assign raw1_s = issue_use_rs1_i && (issue_rs1_i != REG_ZERO) &&
                  (busy_q[issue_rs1_i] || (skid_valid_q && (skid_rd_q == issue_rs1_i)) ||
                   (rf_we_q && (rf_waddr_q == issue_rs1_i)));
  assign raw2_s = issue_use_rs2_i && (issue_rs2_i != REG_ZERO) &&
                  (busy_q[issue_rs2_i] || (skid_valid_q && (skid_rd_q == issue_rs2_i)) ||
                   (rf_we_q && (rf_waddr_q == issue_rs2_i)));
  assign waw_s        = (issue_rd_i != REG_ZERO) && busy_q[issue_rd_i];
  assign full_stall_s = issue_is_load_i && fifo_full_s;
  assign issue_stall_o = issue_valid_i && (raw1_s || raw2_s || waw_s || full_stall_s);

  assign load_push_s = issue_valid_i && !issue_stall_o && issue_is_load_i;
  assign load_win_s  = lsu_rsp_valid_i && !fifo_empty_s;
  assign alu_ready_o = !skid_valid_q;

  rd_fifo #(
    .DEPTH (LOAD_DEPTH),
    .WIDTH (REG_W)
  ) u_rd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (load_push_s),
    .data_i  (issue_rd_i),
    .pop_i   (load_win_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (load_pending_o)
  );

  // Write-port source select: load response, then skid, then direct ALU
  always_comb begin
    wb_src_s  = WB_NONE;
    wb_rd_s   = REG_ZERO;
    wb_data_s = {XLEN{1'b0}};
    if (load_win_s) begin
      wb_src_s  = WB_LOAD;
      wb_rd_s   = fifo_head_s;
      wb_data_s = lsu_rsp_data_i;
    end else if (skid_valid_q) begin
      wb_src_s  = WB_SKID;
      wb_rd_s   = skid_rd_q;
      wb_data_s = skid_data_q;
    end else if (alu_valid_i) begin
      wb_src_s  = WB_ALU;
      wb_rd_s   = alu_rd_i;
      wb_data_s = alu_data_i;
    end else begin
      wb_src_s  = WB_NONE;
    end
  end

  // Skid captures an accepted ALU result that lost the port; it drains when it wins
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (alu_valid_i && alu_ready_o && load_win_s) begin
      skid_valid_d = 1'b1;
      skid_rd_d    = alu_rd_i;
      skid_data_d  = alu_data_i;
    end else if (wb_src_s == WB_SKID) begin
      skid_valid_d = 1'b0;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Busy set on load issue, cleared when that load's write is presented; set wins
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (load_push_s && (issue_rd_i != REG_ZERO) && (issue_rd_i == REG_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (rf_we_q && rf_load_q && (rf_waddr_q == REG_W'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  // State and registered write port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q       <= {NREG{1'b0}};
      skid_valid_q <= 1'b0;
      skid_rd_q    <= REG_ZERO;
      skid_data_q  <= {XLEN{1'b0}};
      rf_we_q      <= 1'b0;
      rf_load_q    <= 1'b0;
      rf_waddr_q   <= REG_ZERO;
      rf_wdata_q   <= {XLEN{1'b0}};
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      rf_we_q      <= (wb_src_s != WB_NONE) && (wb_rd_s != REG_ZERO);
      rf_load_q    <= (wb_src_s == WB_LOAD);
      rf_waddr_q   <= wb_rd_s;
      rf_wdata_q   <= wb_data_s;
      err_q        <= err_q | (lsu_rsp_valid_i & fifo_empty_s);
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Scenario bench for rf_wb_scoreboard; a negedge monitor pops expected register writes.
module tb_rf_wb_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i, issue_use_rs1_i, issue_use_rs2_i, issue_is_load_i;
  logic [4:0]  issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic        issue_stall_o;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_rsp_valid_i;
  logic [31:0] lsu_rsp_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [2:0]  load_pending_o;
  logic        err_o;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      n_pass = 0;
  int      n_chk  = 0;

  rf_wb_scoreboard dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .issue_rs1_i     (issue_rs1_i),
    .issue_rs2_i     (issue_rs2_i),
    .issue_use_rs1_i (issue_use_rs1_i),
    .issue_use_rs2_i (issue_use_rs2_i),
    .issue_is_load_i (issue_is_load_i),
    .issue_stall_o   (issue_stall_o),
    .alu_valid_i     (alu_valid_i),
    .alu_rd_i        (alu_rd_i),
    .alu_data_i      (alu_data_i),
    .alu_ready_o     (alu_ready_o),
    .lsu_rsp_valid_i (lsu_rsp_valid_i),
    .lsu_rsp_data_i  (lsu_rsp_data_i),
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .load_pending_o  (load_pending_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Every register write must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    wb_exp_t e;
    if (rst_ni && rf_we_o) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL wb_unexpected: got x%0d=%h, expected no write", rf_waddr_o, rf_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr_o !== e.addr || rf_wdata_o !== e.data)
          $display("FAIL wb_order: got x%0d=%h, expected x%0d=%h", rf_waddr_o, rf_wdata_o, e.addr, e.data);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0; issue_use_rs1_i = 1'b0; issue_use_rs2_i = 1'b0; issue_is_load_i = 1'b0;
    issue_rd_i = 5'd0; issue_rs1_i = 5'd0; issue_rs2_i = 5'd0;
    alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
    lsu_rsp_valid_i = 1'b0; lsu_rsp_data_i = 32'd0;
  endtask

  task automatic issue_load(input logic [4:0] rd);
    issue_valid_i = 1'b1; issue_is_load_i = 1'b1; issue_rd_i = rd;
    issue_use_rs1_i = 1'b0; issue_use_rs2_i = 1'b0;
    #1;
    n_chk++;
    if (issue_stall_o !== 1'b0) $display("FAIL load_issue_stall: rd=%0d got %b expected 0", rd, issue_stall_o);
    else n_pass++;
    tick();
    issue_valid_i = 1'b0; issue_is_load_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] chk;
    rst_ni = 1'b0;
    idle_inputs();
    #23;
    chk = {rf_we_o, rf_waddr_o != 5'd0, rf_wdata_o != 32'd0, load_pending_o != 3'd0, err_o, ~alu_ready_o, 4'd0};
    n_chk++;
    if (chk !== 10'd0) $display("FAIL reset_outputs: got flags %b expected 0000000000", chk);
    else n_pass++;
    tick();
    rst_ni = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      issue_valid_i = 1'b1; issue_use_rs1_i = 1'b1; issue_use_rs2_i = 1'b1;
      issue_rs1_i = 5'($urandom_range(31, 1)); issue_rs2_i = 5'($urandom_range(31, 1));
      issue_rd_i = 5'($urandom_range(31, 1)); issue_is_load_i = 1'(i & 1);
      #1;
      n_chk++;
      if (issue_stall_o !== 1'b0) $display("FAIL idle_no_stall: iter %0d got %b expected 0", i, issue_stall_o);
      else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_raw_load();
    issue_load(5'd5);
    issue_valid_i = 1'b1; issue_rd_i = 5'd6; issue_rs1_i = 5'd5; issue_use_rs1_i = 1'b1;
    #1;
    n_chk++;
    if (issue_stall_o !== 1'b1 || load_pending_o !== 3'd1)
      $display("FAIL raw_stall: got stall=%b pend=%0d expected stall=1 pend=1", issue_stall_o, load_pending_o);
    else n_pass++;
    tick(); tick();
    lsu_rsp_valid_i = 1'b1; lsu_rsp_data_i = 32'hDEADBEEF;
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
    #1;
    n_chk++;
    if (issue_stall_o !== 1'b1) $display("FAIL raw_hold: got stall=%b expected 1", issue_stall_o);
    else n_pass++;
    tick();
    lsu_rsp_valid_i = 1'b0;
    #1;
    n_chk++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'hDEADBEEF || issue_stall_o !== 1'b1)
      $display("FAIL raw_write: got we=%b x%0d=%h stall=%b expected we=1 x5=deadbeef stall=1",
               rf_we_o, rf_waddr_o, rf_wdata_o, issue_stall_o);
    else n_pass++;
    tick();
    n_chk++;
    if (issue_stall_o !== 1'b0 || rf_we_o !== 1'b0 || load_pending_o !== 3'd0)
      $display("FAIL raw_release: got stall=%b we=%b pend=%0d expected 0 0 0", issue_stall_o, rf_we_o, load_pending_o);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_skid();
    issue_load(5'd9);
    lsu_rsp_valid_i = 1'b1; lsu_rsp_data_i = 32'hCAFE0001;
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h11;
    exp_q.push_back('{addr: 5'd9, data: 32'hCAFE0001});
    exp_q.push_back('{addr: 5'd7, data: 32'h11});
    #1;
    n_chk++;
    if (alu_ready_o !== 1'b1) $display("FAIL skid_ready_pre: got %b expected 1", alu_ready_o);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_chk++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9 || alu_ready_o !== 1'b0)
      $display("FAIL skid_load_first: got we=%b x%0d ready=%b expected we=1 x9 ready=0", rf_we_o, rf_waddr_o, alu_ready_o);
    else n_pass++;
    tick();
    n_chk++;
    if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'h11 || alu_ready_o !== 1'b1)
      $display("FAIL skid_drain: got we=%b x%0d=%h ready=%b expected we=1 x7=11 ready=1",
               rf_we_o, rf_waddr_o, rf_wdata_o, alu_ready_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) issue_load(5'(i));
    n_chk++;
    if (load_pending_o !== 3'd4) $display("FAIL full_count: got %0d expected 4", load_pending_o);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      lsu_rsp_valid_i = 1'b1; lsu_rsp_data_i = 32'hA0000000 + 32'(i);
      exp_q.push_back('{addr: 5'(i), data: 32'hA0000000 + 32'(i)});
      if (i == 1) begin
        issue_valid_i = 1'b1; issue_is_load_i = 1'b1; issue_rd_i = 5'd10;
        #1;
        n_chk++;
        if (issue_stall_o !== 1'b1) $display("FAIL full_stall: got %b expected 1", issue_stall_o);
        else n_pass++;
      end
      tick();
      issue_valid_i = 1'b0; issue_is_load_i = 1'b0;
      n_chk++;
      if (load_pending_o !== 3'(4 - i)) $display("FAIL full_drain: step %0d got %0d expected %0d", i, load_pending_o, 4 - i);
      else n_pass++;
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_x0();
    issue_load(5'd0);
    issue_valid_i = 1'b1; issue_rd_i = 5'd0; issue_use_rs1_i = 1'b1; issue_use_rs2_i = 1'b1;
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h55;
    #1;
    n_chk++;
    if (issue_stall_o !== 1'b0 || load_pending_o !== 3'd1)
      $display("FAIL x0_no_stall: got stall=%b pend=%0d expected 0 1", issue_stall_o, load_pending_o);
    else n_pass++;
    tick();
    idle_inputs();
    lsu_rsp_valid_i = 1'b1; lsu_rsp_data_i = 32'h77;
    n_chk++;
    if (rf_we_o !== 1'b0) $display("FAIL x0_alu_drop: got we=%b expected 0", rf_we_o);
    else n_pass++;
    tick();
    lsu_rsp_valid_i = 1'b0;
    n_chk++;
    if (rf_we_o !== 1'b0 || load_pending_o !== 3'd0 || err_o !== 1'b0)
      $display("FAIL x0_load_drop: got we=%b pend=%0d err=%b expected 0 0 0", rf_we_o, load_pending_o, err_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_err();
    lsu_rsp_valid_i = 1'b1; lsu_rsp_data_i = 32'h99;
    tick();
    lsu_rsp_valid_i = 1'b0;
    n_chk++;
    if (err_o !== 1'b1 || rf_we_o !== 1'b0) $display("FAIL err_set: got err=%b we=%b expected 1 0", err_o, rf_we_o);
    else n_pass++;
    tick(); tick();
    n_chk++;
    if (err_o !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    issue_load(5'd12);
    alu_valid_i = 1'b1; alu_rd_i = 5'd13; alu_data_i = 32'h1234;
    exp_q.push_back('{addr: 5'd13, data: 32'h1234});
    tick();
    alu_valid_i = 1'b0;
    n_chk++;
    if (rf_we_o !== 1'b1 || load_pending_o !== 3'd1)
      $display("FAIL prereset_state: got we=%b pend=%0d expected 1 1", rf_we_o, load_pending_o);
    else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_chk++;
    if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 || load_pending_o !== 3'd0 || err_o !== 1'b0)
      $display("FAIL async_reset: got we=%b x%0d=%h pend=%0d err=%b expected all zero",
               rf_we_o, rf_waddr_o, rf_wdata_o, load_pending_o, err_o);
    else n_pass++;
    // the write to x13 was wiped by reset before the monitor could see it
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    tick();
    rst_ni = 1'b1;
    issue_valid_i = 1'b1; issue_rd_i = 5'd12; issue_rs1_i = 5'd12; issue_use_rs1_i = 1'b1; issue_is_load_i = 1'b1;
    #1;
    n_chk++;
    if (issue_stall_o !== 1'b0) $display("FAIL reset_clears_busy: got stall=%b expected 0", issue_stall_o);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_raw_load();
    test_skid();
    test_full();
    test_x0();
    test_err();
    test_async_reset();
    tick();
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL writes_missing: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_wb_scoreboard.md
Name: rf_wb_scoreboard

Overview:
- Writer-side controller for the 32x32 register file.
- Owns the single register-file write port (data, destination index, write enable) and arbitrates between ALU results and out-of-order-latency (in-order-return) load responses.
- Keeps a per-register busy scoreboard so the decode/issue stage stalls on RAW/WAW hazards against pending writes.
- Sits between issue, the ALU/LSU result paths and the register file.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero)
- XLEN, 32, data width
- LOAD_DEPTH, 4, max outstanding loads (power of two, >=2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  instruction presented at issue
- issue_rd_i  in  5  destination register
- issue_rs1_i / issue_rs2_i  in  5  source registers
- issue_use_rs1_i / issue_use_rs2_i  in  1  source actually read
- issue_is_load_i  in  1  instruction is a load
- issue_stall_o  out  1  combinational; issue must hold
- alu_valid_i  in  1  ALU result valid
- alu_rd_i  in  5  ALU destination
- alu_data_i  in  XLEN  ALU result
- alu_ready_o  out  1  ALU result accepted this cycle
- lsu_rsp_valid_i  in  1  load data returning; no backpressure, in issue order
- lsu_rsp_data_i  in  XLEN  load data
- rf_we_o  out  1  register-file write enable (registered)
- rf_waddr_o  out  5  register-file write index (registered)
- rf_wdata_o  out  XLEN  register-file write data (registered)
- load_pending_o  out  $clog2(LOAD_DEPTH)+1  outstanding load count
- err_o  out  1  sticky: load response with no outstanding load

Behaviour:
- Reset (async, rst_ni=0): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy[]=0, load FIFO empty, skid empty, load_pending_o=0, err_o=0. A mid-operation reset discards every pending load and skid entry.
- Accept: issue_fire = issue_valid_i & !issue_stall_o.
- issue_stall_o=1 if issue_valid_i and any of the following holds:
  - RAW: used rsN!=0 and (busy[rsN], or skid valid with skid_rd==rsN, or rf_we_o with rf_waddr_o==rsN).
  - WAW: rd!=0 and busy[rd].
  - Full: issue_is_load_i and load FIFO full. A pop in the same cycle does not relieve full.
- Load issue (issue_fire & is_load): push rd into the load FIFO; if rd!=0, set busy[rd] at that edge.
- Write-port priority each cycle:
  1. lsu_rsp_valid_i pops the FIFO head.
  2. Else skid entry.
  3. Else direct alu_valid_i.
- Selected source registers into rf_* with 1-cycle latency. rf_we_o=1 only if the selected rd!=0; writes to x0 are dropped but still consume the slot.
- busy[rd] clears on the edge where rf_we_o=1 with rf_waddr_o==rd and that write originates from a load. This is the same edge on which the regfile captures the data.
- ALU path:
  - alu_ready_o = !skid_valid.
  - If alu_valid_i & alu_ready_o and a load response or skid wins the port, the ALU result is captured in the skid (1 entry).
  - The skid drains on the first cycle with no load response.
- Load response with FIFO empty: ignored (no write), err_o set until reset.
- A set and a clear of busy bits on the same edge target different registers by construction (WAW stall). If both target the same register, set wins.
- FIFO pointers wrap modulo LOAD_DEPTH; the count is held separately (full = count==LOAD_DEPTH).

Decomposition:
- Shared package rv_pkg:
  - XLEN, NREG and the register-index width
  - REG_ZERO constant
  - wb_src_e enum {WB_NONE, WB_LOAD, WB_SKID, WB_ALU} for the port mux select
- One sub-module: rd_fifo (parameterised depth/width, push/pop/full/empty/count) holding outstanding load destinations.
- Scoreboard, skid and write-port mux stay in the top.

Test Plan:
- Reset then idle: rf_we_o=0, issue_stall_o=0 for any issue, load_pending_o=0, err_o=0.
- Load to x5, then add reading rs1=x5 → stall held until the response (data 0xDEADBEEF). Required: rf_we_o=1, waddr=5, wdata=0xDEADBEEF one cycle after the response; stall drops the following cycle.
- Load response and alu_valid (rd=7, data=0x11) in the same cycle:
  - Cycle+1: load write.
  - Cycle+2: write x7=0x11.
  - alu_ready_o=0 while the skid is full.
- Issue 4 loads (rd=1..4) back-to-back: 5th load stalls (full) even with a response that cycle; responses write x1..x4 in order; load_pending_o counts 4→0.
- Load to x0 and ALU write to x0: no rf_we_o pulse, no stall on rs=x0, FIFO entry still consumed.
- lsu_rsp_valid_i with no outstanding load → err_o=1 sticky, no write. Assert rst_ni=0 mid-load: all outputs return to reset values asynchronously.
